seq_alu_core: RTL and testbench
===============================

// Module: seq_alu_core
// PURPOSE
//  Parametrised sequential ALU datapath for the board top. Operands are keyed in one bit
//   at a time through an internal serial-entry shift register with edge-detected push inputs.
//  Entry value is latched into A or B; a started op produces a 2W-bit result, flags and a
//   one-cycle done pulse. MUL is iterative (shift-add, W cycles); other ops take one cycle.
//  Top-level seven-segment decoders read entry_val, a_val, b_val and result.
// PARAMETERS
//  W      8   operand width in bits (>=4, power of 2)
//  SHW    $clog2(W)   derived: shift-amount width, taken from B[SHW-1:0]
// PORTS
//  clk        in   1     system clock (hz100 at top)
//  rstn       in   1     synchronous active-low reset
//  push0      in   1     raw level: shift a 0 into entry reg (rising edge only)
//  push1      in   1     raw level: shift a 1 into entry reg (rising edge only)
//  dir        in   1     0: shift toward MSB (new bit at [0]); 1: toward LSB (new bit at [W-1])
//  clr_entry  in   1     level: clear entry reg next cycle
//  load_a     in   1     level: A <= entry_val (ignored while busy)
//  load_b     in   1     level: B <= entry_val (ignored while busy)
//  op         in   3     alu_op_t, sampled on accepted start
//  start      in   1     request op; accepted only in IDLE
//  entry_val  out  W     entry shift register
//  a_val      out  W     operand A;  b_val out W  operand B
//  result     out  2W    last result, held until next accepted start
//  flag_z/c/n/v out 1 each  zero, carry/borrow, negative (result[W-1]), signed overflow
//  busy       out  1     high from accept until done cycle inclusive
//  done       out  1     one-cycle pulse when result/flags valid
// BEHAVIOUR
//  Reset (rstn=0 at clk edge): every output and register 0, FSM=IDLE, sync flops 0.
//  Edge detect: per push input, 2-flop chain (sync, prev); pulse = sync & ~prev. Held level
//   gives exactly one shift. Both pulses same cycle -> single shift of 1.
//  clr_entry has priority over a shift in the same cycle.
//  load_a and load_b both high -> both load the same entry_val.
//  FSM: IDLE --start--> EXEC(MUL) or DONE(other ops); EXEC counts W cycles -> DONE;
//   DONE -> IDLE unconditionally. start outside IDLE ignored (no queuing).
//  Latency from accepting edge: single-cycle ops done at +1; MUL done at +W+1.
//  Ops (A,B unsigned unless noted; result upper bits zero unless stated):
//   ADD: result[W:0]=A+B, c=result[W]. SUB: result[W-1:0]=A-B, c=borrow(A<B).
//   AND/OR/XOR bitwise, c=0,v=0. SHL: A<<B[SHW-1:0], c=last bit shifted out.
//   SHR: logical A>>B[SHW-1:0], c=last bit shifted out; shift 0 -> c=0.
//   MUL: unsigned 2W product, c=|result[2W-1:W], v=0.
//  v: ADD/SUB two's-complement overflow on W bits; else 0. z: result==0 over full 2W.
//  n = result[W-1] for all ops except MUL, where n = result[2W-1].
//  Operands captured into working regs on accept; later A/B loads cannot corrupt an op.
//  Reset mid-MUL aborts: result/flags 0, IDLE, no done.
// STRUCTURE
//  alu_pkg: typedef enum logic [2:0] alu_op_t {ADD,SUB,AND,OR,XOR,SHL,SHR,MUL};
//   typedef enum state_t {IDLE,EXEC,DONE}.
//  Sub-module edge_pulse (2-flop sync + rise detect), instantiated twice.
//  Entry shift register inline; MUL uses W-bit multiplicand shift, accumulator, counter.
// TESTING (W=8)
//  push1,push0,push1,push1 (dir=0), each held 5 cycles -> entry_val=8'h0B, one shift per press.
//  A=8'hF0,B=8'h20,ADD -> result=16'h0110, c=1, z=0, done at +1.
//  A=8'h7F,B=8'hFF,SUB -> result[7:0]=8'h80, c=1, v=1, n=1.
//  A=8'hFF,B=8'hFF,MUL -> busy 9 cycles, done at +9, result=16'hFE01, c=1;
//   start and load_a mid-op ignored.
//  A=8'h81,B=8'h01,SHL -> result=16'h0002, c=1; SHR B=0 -> result=16'h0081, c=0.
//  rstn low at MUL cycle 4 -> result=0, busy=0, no done; next ADD works normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU core.
// Operation encoding and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SHL = 3'd5,
    SHR = 3'd6,
    MUL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/edge_pulse.sv
// Two-flop synchroniser with rising-edge detect.
// Ports: clk, rstn (sync, active low), level in, one-cycle pulse out.
module edge_pulse (
  input  logic clk,
  input  logic rstn,
  input  logic level,
  output logic pulse
);

  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= level;
      prev_q <= sync_q;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/seq_alu_core.sv
// Sequential ALU: serial operand entry, A/B regs, 1-cycle ops, iterative MUL.
// Ports: clk, rstn, push0/1, dir, clr_entry, load_a/b, op, start -> entry/a/b/result, flags, busy, done.
module seq_alu_core
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           push0,
  input  logic           push1,
  input  logic           dir,
  input  logic           clr_entry,
  input  logic           load_a,
  input  logic           load_b,
  input  alu_op_t        op,
  input  logic           start,
  output logic [W-1:0]   entry_val,
  output logic [W-1:0]   a_val,
  output logic [W-1:0]   b_val,
  output logic [2*W-1:0] result,
  output logic           flag_z,
  output logic           flag_c,
  output logic           flag_n,
  output logic           flag_v,
  output logic           busy,
  output logic           done
);

  localparam int SHW = $clog2(W);

  logic p0, p1, shift_en;
  state_t st_q, st_d;
  logic [2*W-1:0] mcand, acc, acc_nx, res_c;
  logic [W-1:0] mplier;
  logic [SHW-1:0] cnt, sh;
  logic last, accept;
  logic [W:0] sum, dif, shl, shr;
  logic c_c, v_c;

  edge_pulse u_ep0 (.clk(clk), .rstn(rstn), .level(push0), .pulse(p0));
  edge_pulse u_ep1 (.clk(clk), .rstn(rstn), .level(push1), .pulse(p1));

  // A simultaneous 0 and 1 press collapses to one shift of 1.
  assign shift_en = p0 | p1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      entry_val <= '0;
    end else if (clr_entry) begin
      entry_val <= '0;
    end else if (shift_en) begin
      if (dir) entry_val <= {p1, entry_val[W-1:1]};
      else     entry_val <= {entry_val[W-2:0], p1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_val <= '0;
      b_val <= '0;
    end else if (st_q == IDLE) begin
      if (load_a) a_val <= entry_val;
      if (load_b) b_val <= entry_val;
    end
  end

  assign accept = (st_q == IDLE) && start;
  assign last   = (cnt == SHW'(W-1));
  assign sh     = b_val[SHW-1:0];
  assign acc_nx = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    sum   = {1'b0, a_val} + {1'b0, b_val};
    dif   = {1'b0, a_val} - {1'b0, b_val};
    shl   = {1'b0, a_val} << sh;
    shr   = {a_val, 1'b0} >> sh;
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    unique case (op)
      ADD: begin
        res_c[W:0] = sum;
        c_c = sum[W];
        v_c = (a_val[W-1] == b_val[W-1]) && (sum[W-1] != a_val[W-1]);
      end
      SUB: begin
        res_c[W-1:0] = dif[W-1:0];
        c_c = dif[W];
        v_c = (a_val[W-1] != b_val[W-1]) && (dif[W-1] != a_val[W-1]);
      end
      AND: res_c[W-1:0] = a_val & b_val;
      OR:  res_c[W-1:0] = a_val | b_val;
      XOR: res_c[W-1:0] = a_val ^ b_val;
      SHL: begin
        res_c[W-1:0] = shl[W-1:0];
        c_c = shl[W];
      end
      SHR: begin
        res_c[W-1:0] = shr[W:1];
        c_c = shr[0];
      end
      MUL: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) st_q <= IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (start) st_d = (op == MUL) ? EXEC : DONE;
      EXEC:    if (last) st_d = DONE;
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Single-cycle results are registered on accept; MUL on its last step.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept) begin
      if (op == MUL) begin
        mcand  <= {{W{1'b0}}, a_val};
        mplier <= b_val;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        result <= res_c;
        flag_z <= (res_c == '0);
        flag_c <= c_c;
        flag_n <= res_c[W-1];
        flag_v <= v_c;
      end
    end else if (st_q == EXEC) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) begin
        result <= acc_nx;
        flag_z <= (acc_nx == '0);
        flag_c <= |acc_nx[2*W-1:W];
        flag_n <= acc_nx[2*W-1];
        flag_v <= 1'b0;
      end
    end
  end

  assign busy = (st_q != IDLE);
  assign done = (st_q == DONE);

endmodule

// File: tb/tb_seq_alu_core.sv
// Directed bench for seq_alu_core (W=8).
// Drives and samples on the falling edge.
module tb_seq_alu_core;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rstn, push0, push1, dir, clr_entry;
  logic load_a, load_b, start;
  alu_op_t op;
  logic [7:0] entry_val, a_val, b_val;
  logic [15:0] result;
  logic flag_z, flag_c, flag_n, flag_v, busy, done;

  int n_vec = 0;
  int n_err = 0;
  int done_at, busy_n, done_n;

  always #5 clk = ~clk;

  seq_alu_core #(.W(8)) dut (
    .clk(clk), .rstn(rstn), .push0(push0), .push1(push1),
    .dir(dir), .clr_entry(clr_entry), .load_a(load_a),
    .load_b(load_b), .op(op), .start(start),
    .entry_val(entry_val), .a_val(a_val), .b_val(b_val),
    .result(result), .flag_z(flag_z), .flag_c(flag_c),
    .flag_n(flag_n), .flag_v(flag_v), .busy(busy), .done(done)
  );

  task automatic press(input logic b, input int hold);
    if (b) push1 = 1'b1; else push0 = 1'b1;
    repeat (hold) @(negedge clk);
    push0 = 1'b0; push1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] v);
    dir = 1'b0; clr_entry = 1'b1;
    @(negedge clk); clr_entry = 1'b0;
    for (int i = 7; i >= 0; i--) press(v[i], 2);
  endtask

  task automatic load(input logic [7:0] v, input logic la, input logic lb);
    key(v);
    load_a = la; load_b = lb;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0;
  endtask

  task automatic run_op(input alu_op_t o, input logic inject);
    op = o; start = 1'b1;
    @(negedge clk); start = 1'b0;
    done_at = 0; busy_n = 0; done_n = 0;
    for (int k = 1; k <= 16; k++) begin
      if (busy) busy_n++;
      if (done) done_n++;
      if (done && done_at == 0) done_at = k;
      if (inject && k == 3) begin
        op = ADD; start = 1'b1; load_a = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; load_a = 1'b0;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    n_vec++;
    if ({entry_val, a_val, b_val, result} !== 40'h0) begin
      n_err++;
      $display("FAIL reset_regs got %h want 0", {entry_val, a_val, b_val, result});
    end
    n_vec++;
    if ({flag_z, flag_c, flag_n, flag_v, busy, done} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl got %b want 000000", {flag_z, flag_c, flag_n, flag_v, busy, done});
    end
  endtask

  task automatic test_entry;
    dir = 1'b0;
    press(1'b1, 5);
    n_vec++;
    if (entry_val !== 8'h01) begin
      n_err++; $display("FAIL entry_one_press got %h want 01", entry_val);
    end
    press(1'b0, 5); press(1'b1, 5); press(1'b1, 5);
    n_vec++;
    if (entry_val !== 8'h0B) begin
      n_err++; $display("FAIL entry_seq got %h want 0b", entry_val);
    end
    dir = 1'b1;
    press(1'b1, 5);
    n_vec++;
    if (entry_val !== 8'h85) begin
      n_err++; $display("FAIL entry_dir1 got %h want 85", entry_val);
    end
    dir = 1'b0;
    push0 = 1'b1; push1 = 1'b1;
    repeat (4) @(negedge clk);
    push0 = 1'b0; push1 = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (entry_val !== 8'h0B) begin
      n_err++; $display("FAIL entry_both got %h want 0b", entry_val);
    end
    push1 = 1'b1;
    @(negedge clk); clr_entry = 1'b1;
    @(negedge clk); clr_entry = 1'b0; push1 = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (entry_val !== 8'h00) begin
      n_err++; $display("FAIL entry_clr_prio got %h want 00", entry_val);
    end
  endtask

  task automatic test_load_both;
    load(8'h5A, 1'b1, 1'b1);
    n_vec++;
    if ({a_val, b_val} !== 16'h5A5A) begin
      n_err++; $display("FAIL load_both got %h want 5a5a", {a_val, b_val});
    end
  endtask

  task automatic test_add;
    load(8'hF0, 1'b1, 1'b0);
    load(8'h20, 1'b0, 1'b1);
    run_op(ADD, 1'b0);
    n_vec++;
    if (result !== 16'h0110) begin
      n_err++; $display("FAIL add_res got %h want 0110", result);
    end
    n_vec++;
    if ({flag_z, flag_c, flag_n, flag_v} !== 4'b0100) begin
      n_err++; $display("FAIL add_flags got %b want 0100", {flag_z, flag_c, flag_n, flag_v});
    end
    n_vec++;
    if (done_at !== 1 || busy_n !== 1 || done_n !== 1) begin
      n_err++;
      $display("FAIL add_timing got done_at=%0d busy=%0d dones=%0d want 1 1 1", done_at, busy_n, done_n);
    end
  endtask

  task automatic test_sub;
    load(8'h7F, 1'b1, 1'b0);
    load(8'hFF, 1'b0, 1'b1);
    run_op(SUB, 1'b0);
    n_vec++;
    if (result !== 16'h0080) begin
      n_err++; $display("FAIL sub_res got %h want 0080", result);
    end
    n_vec++;
    if ({flag_z, flag_c, flag_n, flag_v} !== 4'b0111) begin
      n_err++; $display("FAIL sub_flags got %b want 0111", {flag_z, flag_c, flag_n, flag_v});
    end
  endtask

  task automatic test_mul;
    load(8'hFF, 1'b1, 1'b1);
    key(8'h12);
    run_op(MUL, 1'b1);
    n_vec++;
    if (result !== 16'hFE01) begin
      n_err++; $display("FAIL mul_res got %h want fe01", result);
    end
    n_vec++;
    if ({flag_z, flag_c, flag_n, flag_v} !== 4'b0110) begin
      n_err++; $display("FAIL mul_flags got %b want 0110", {flag_z, flag_c, flag_n, flag_v});
    end
    n_vec++;
    if (done_at !== 9 || busy_n !== 9 || done_n !== 1) begin
      n_err++;
      $display("FAIL mul_timing got done_at=%0d busy=%0d dones=%0d want 9 9 1", done_at, busy_n, done_n);
    end
    n_vec++;
    if (a_val !== 8'hFF) begin
      n_err++; $display("FAIL mul_load_ignored got %h want ff", a_val);
    end
  endtask

  task automatic test_shift;
    load(8'h81, 1'b1, 1'b0);
    load(8'h01, 1'b0, 1'b1);
    run_op(SHL, 1'b0);
    n_vec++;
    if ({result, flag_c, flag_n} !== {16'h0002, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL shl got res=%h c=%b n=%b want 0002 1 0", result, flag_c, flag_n);
    end
    run_op(SHR, 1'b0);
    n_vec++;
    if ({result, flag_c} !== {16'h0040, 1'b1}) begin
      n_err++; $display("FAIL shr1 got res=%h c=%b want 0040 1", result, flag_c);
    end
    load(8'h00, 1'b0, 1'b1);
    run_op(SHR, 1'b0);
    n_vec++;
    if ({result, flag_c, flag_n} !== {16'h0081, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL shr0 got res=%h c=%b n=%b want 0081 0 1", result, flag_c, flag_n);
    end
    run_op(AND, 1'b0);
    n_vec++;
    if ({result, flag_z, flag_c} !== {16'h0000, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL and_zero got res=%h z=%b c=%b want 0000 1 0", result, flag_z, flag_c);
    end
  endtask

  task automatic test_reset_mid_mul;
    load(8'hFF, 1'b1, 1'b1);
    op = MUL; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    n_vec++;
    if ({result, busy, done, flag_c, flag_n} !== 20'h0) begin
      n_err++;
      $display("FAIL mid_rst got res=%h busy=%b done=%b c=%b n=%b want 0", result, busy, done, flag_c, flag_n);
    end
    done_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) done_n++;
      @(negedge clk);
    end
    n_vec++;
    if (done_n !== 0) begin
      n_err++; $display("FAIL mid_rst_quiet got %0d active cycles want 0", done_n);
    end
    load(8'h05, 1'b1, 1'b0);
    load(8'h03, 1'b0, 1'b1);
    run_op(ADD, 1'b0);
    n_vec++;
    if ({result, flag_z, flag_c, done_at} !== {16'h0008, 1'b0, 1'b0, 32'd1}) begin
      n_err++; $display("FAIL post_rst_add got res=%h done_at=%0d want 0008 1", result, done_at);
    end
  endtask

  initial begin
    rstn = 1'b0; push0 = 1'b0; push1 = 1'b0; dir = 1'b0;
    clr_entry = 1'b0; load_a = 1'b0; load_b = 1'b0;
    start = 1'b0; op = ADD;
    @(negedge clk);
    test_reset;
    test_entry;
    test_load_both;
    test_add;
    test_sub;
    test_mul;
    test_shift;
    test_reset_mid_mul;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
